reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  Architectural register file for the 8-bit core. Sits directly upstream of
//  the ALU: supplies rs1_data/rd_data for the instruction fetched from Im, and
//  accepts the ALU result for write-back. Also carries a debug dump engine that
//  streams every register out over a valid/ready port for bench inspection.
// PARAMETERS
//  DATA_W    8   register width (matches ALU operand width)
//  ADDR_W    2   register index width
//  NUM_REGS  4   register count; must equal 2**ADDR_W
// PORTS
//  clk        in   1       core clock; all state updates on rising edge
//  startup    in   1       synchronous reset, active-low (0 = reset)
//  rs1_addr   in   ADDR_W  read port A index
//  rd_addr    in   ADDR_W  read port B index (destination operand)
//  rs1_data   out  DATA_W  read port A data (combinational)
//  rd_data    out  DATA_W  read port B data (combinational)
//  wr_en      in   1       write-back enable
//  wr_addr    in   ADDR_W  write-back index
//  wr_data    in   DATA_W  write-back data (ALU out)
//  dump_req   in   1       start debug dump (level, sampled in IDLE only)
//  dbg_valid  out  1       dbg_addr/dbg_data hold a register snapshot
//  dbg_ready  in   1       consumer accepts current snapshot
//  dbg_addr   out  ADDR_W  index of register being dumped
//  dbg_data   out  DATA_W  value of register being dumped
//  dbg_done   out  1       one-cycle pulse after last register accepted
// BEHAVIOUR
//  - Reset (startup==0 at rising edge): all registers <= 0, FSM <= IDLE,
//    dump index <= 0; dbg_valid=0, dbg_done=0, dbg_addr=0, dbg_data=0.
//    Reset overrides wr_en and aborts any dump in progress (no dbg_done).
//  - Reads: combinational, zero latency; rs1_data=reg[rs1_addr],
//    rd_data=reg[rd_addr]. Both ports may address the same register.
//  - Write: when startup==1 and wr_en==1, reg[wr_addr] <= wr_data at the edge;
//    visible on read ports the following cycle (see REGFILE_BYPASS_EN).
//  - Dump FSM states: IDLE, WALK, DONE.
//    IDLE: dbg_valid=0. dump_req==1 -> WALK with idx=0.
//    WALK: dbg_valid=1, dbg_addr=idx, dbg_data=reg[idx] (current stored value).
//      dbg_valid&dbg_ready: idx==NUM_REGS-1 -> DONE, else idx<=idx+1.
//      dbg_ready==0: hold idx; dbg_data tracks reg[idx] if it is written.
//    DONE: dbg_done=1 for exactly one cycle, dbg_valid=0 -> IDLE.
//  - dump_req ignored in WALK and DONE; held high it restarts from IDLE.
//  - Write to reg[idx] in the accepting cycle: dump reports pre-write value.
//  - Write-back never stalls; dump is read-only and never blocks core ops.
//  - Widths: no arithmetic on data; idx is ADDR_W bits, no wrap past last reg.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: when wr_en==1 and wr_addr equals a read index,
//    that read port returns wr_data in the same cycle (write-through).
//    Applies to rs1_data and rd_data only, not dbg_data.
//  Undefined: read ports always return the stored (pre-write) value.
// TESTING
//  1 Reset: startup=0 one edge after writes -> all reads 0, dbg_valid=0.
//  2 Write/read: wr r2<=8'hA5, next cycle rs1_addr=2,rd_addr=2 -> both 8'hA5;
//    other regs still 8'h00.
//  3 Same-cycle hazard: reg1=8'h11, wr r1<=8'h22 with rs1_addr=1 -> 8'h22 if
//    REGFILE_BYPASS_EN, else 8'h11; next cycle 8'h22 both builds.
//  4 Dump, ready=1: regs {0:01,1:02,2:03,3:04}, pulse dump_req -> 4 cycles
//    dbg_valid with (0,01),(1,02),(2,03),(3,04), then dbg_done one cycle.
//  5 Backpressure: dbg_ready=0 for 3 cycles at idx 1 -> dbg_addr holds 1;
//    write r1<=8'h7E during stall -> dbg_data shows 8'h7E when accepted.
//  6 Reset mid-dump at idx 2 -> next cycle dbg_valid=0, no dbg_done, IDLE.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: architectural register file for the 8-bit core.
//   Two combinational read ports (rs1, rd) feed the ALU, and one write-back
//   port takes the ALU result. A debug dump engine walks every register
//   out over a valid/ready port and pulses dbg_done after the last one.
//
// Ports:
//   clk                core clock, rising edge
//   startup            synchronous reset, active-low
//   rs1_addr/rs1_data  read port A (combinational)
//   rd_addr/rd_data    read port B (combinational)
//   wr_en/wr_addr/wr_data  write-back port
//   dump_req           start a dump (level, sampled only while idle)
//   dbg_valid/dbg_ready    dump handshake
//   dbg_addr/dbg_data  register index/value being dumped
//   dbg_done           one-cycle pulse after the last register is accepted
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   -> a same-cycle write to a read index is forwarded to
//                rs1_data/rd_data (dbg_data is never forwarded)
//   undefined -> read ports always return the stored value
module reg_file #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              startup,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              dump_req,
  output logic              dbg_valid,
  input  logic              dbg_ready,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_done
);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] regs [NUM_REGS];
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;

  // Register storage; reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (!startup) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    rs1_data = (startup && wr_en && (wr_addr == rs1_addr)) ? wr_data : regs[rs1_addr];
    rd_data  = (startup && wr_en && (wr_addr == rd_addr))  ? wr_data : regs[rd_addr];
`else
    rs1_data = regs[rs1_addr];
    rd_data  = regs[rd_addr];
`endif
  end

  // Dump FSM: state register.
  always_ff @(posedge clk) begin
    if (!startup) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Dump FSM: next state. dbg_valid is 1 throughout WALK, so acceptance
  // reduces to dbg_ready there.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      IDLE: begin
        if (dump_req) begin
          state_nxt = WALK;
          idx_nxt   = '0;
        end
      end
      WALK: begin
        if (dbg_ready) begin
          if (idx == LAST_IDX) state_nxt = DONE;
          else                 idx_nxt   = idx + ADDR_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Dump FSM: outputs. dbg_data reads storage directly, so a write in the
  // accepting cycle is reported with its pre-write value, and a write during
  // a stall shows up the following cycle.
  always_comb begin
    dbg_valid = 1'b0;
    dbg_done  = 1'b0;
    dbg_addr  = '0;
    dbg_data  = '0;
    unique case (state)
      WALK: begin
        dbg_valid = 1'b1;
        dbg_addr  = idx;
        dbg_data  = regs[idx];
      end
      DONE:    dbg_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file. Directed scenarios followed
// by a randomized phase; every cycle all outputs are compared against a
// reference model (array of register values plus a queue of indices still
// to be dumped).
module tb_reg_file;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned NUM_REGS = 4;

  logic              clk = 1'b0;
  logic              startup;
  logic [ADDR_W-1:0] rs1_addr, rd_addr, wr_addr, dbg_addr;
  logic [DATA_W-1:0] rs1_data, rd_data, wr_data, dbg_data;
  logic              wr_en, dump_req, dbg_valid, dbg_ready, dbg_done;

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .startup(startup),
    .rs1_addr(rs1_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dump_req(dump_req), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_done(dbg_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model.
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  int unsigned       m_todo [$];   // indices not yet accepted in current dump
  bit                m_done;       // done pulse due this cycle

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
    if (startup && wr_en && wr_addr == a) return wr_data;
`endif
    return m_regs[a];
  endfunction

  // Move to mid-cycle (negedge) and compare every output with the model.
  task automatic settle();
    bit v;
    #4;
    v = (m_todo.size() > 0);
    chk("rs1_data", 32'(rs1_data), 32'(exp_read(rs1_addr)));
    chk("rd_data",  32'(rd_data),  32'(exp_read(rd_addr)));
    chk("dbg_valid", 32'(dbg_valid), 32'(v));
    chk("dbg_addr", 32'(dbg_addr), v ? m_todo[0] : 32'd0);
    chk("dbg_data", 32'(dbg_data), v ? 32'(m_regs[m_todo[0]]) : 32'd0);
    chk("dbg_done", 32'(dbg_done), 32'(m_done));
  endtask

  // Take the rising edge and apply the behavioural rules to the model.
  task automatic advance();
    bit nd;
    @(posedge clk);
    if (!startup) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_todo.delete();
      m_done = 1'b0;
    end else begin
      nd = 1'b0;
      if (m_todo.size() > 0) begin
        if (dbg_ready) begin
          void'(m_todo.pop_front());
          if (m_todo.size() == 0) nd = 1'b1;
        end
      end else if (!m_done && dump_req) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) m_todo.push_back(i);
      end
      m_done = nd;
      if (wr_en) m_regs[wr_addr] = wr_data;
    end
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    startup = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rs1_addr = '0; rd_addr = '0; dump_req = 1'b0; dbg_ready = 1'b1;
  endtask

  initial begin
    idle_inputs();
    startup = 1'b0;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_done = 1'b0;
    @(posedge clk); #1;

    // 1: reset after writes clears everything.
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = 8'h30 + 8'(i); tick();
    end
    wr_en = 1'b0; dump_req = 1'b1; tick();
    dump_req = 1'b0; dbg_ready = 1'b0; tick();
    startup = 1'b0; tick();
    startup = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rs1_addr = ADDR_W'(i); rd_addr = ADDR_W'(3 - i); settle();
      chk("reset_rs1", 32'(rs1_data), 32'h0);
      chk("reset_rd", 32'(rd_data), 32'h0);
      chk("reset_valid", 32'(dbg_valid), 32'h0);
      advance();
    end
    dbg_ready = 1'b1;

    // 2: write r2 then read it on both ports.
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5; tick();
    wr_en = 1'b0; rs1_addr = 2'd2; rd_addr = 2'd2; settle();
    chk("wr_rd_rs1", 32'(rs1_data), 32'hA5);
    chk("wr_rd_rd", 32'(rd_data), 32'hA5);
    advance();
    rs1_addr = 2'd0; rd_addr = 2'd3; settle();
    chk("other_r0", 32'(rs1_data), 32'h00);
    chk("other_r3", 32'(rd_data), 32'h00);
    advance();

    // 3: same-cycle read/write hazard on r1.
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h11; tick();
    wr_data = 8'h22; rs1_addr = 2'd1; settle();
`ifdef REGFILE_BYPASS_EN
    chk("hazard_same", 32'(rs1_data), 32'h22);
`else
    chk("hazard_same", 32'(rs1_data), 32'h11);
`endif
    advance();
    wr_en = 1'b0; settle();
    chk("hazard_next", 32'(rs1_data), 32'h22);
    advance();

    // 4: full dump with ready held high.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = 8'(i + 1); tick();
    end
    wr_en = 1'b0; dump_req = 1'b1; tick();
    dump_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("dump_valid", 32'(dbg_valid), 32'h1);
      chk("dump_addr", 32'(dbg_addr), 32'(i));
      chk("dump_data", 32'(dbg_data), 32'(i + 1));
      advance();
    end
    settle();
    chk("dump_done", 32'(dbg_done), 32'h1);
    chk("dump_done_valid", 32'(dbg_valid), 32'h0);
    advance();
    settle();
    chk("dump_done_once", 32'(dbg_done), 32'h0);
    advance();

    // 5: backpressure at idx 1 with a write to r1 during the stall.
    dump_req = 1'b1; tick();
    dump_req = 1'b0; tick();
    dbg_ready = 1'b0; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h7E;
    settle();
    chk("stall_addr0", 32'(dbg_addr), 32'h1);
    advance();
    wr_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("stall_addr", 32'(dbg_addr), 32'h1);
      chk("stall_data", 32'(dbg_data), 32'h7E);
      advance();
    end
    dbg_ready = 1'b1; settle();
    chk("stall_accept", 32'(dbg_data), 32'h7E);
    advance();
    for (int i = 0; i < 4; i++) tick();

    // 6: reset mid-dump at idx 2.
    dump_req = 1'b1; tick();
    dump_req = 1'b0; tick(); tick();
    settle();
    chk("abort_at2", 32'(dbg_addr), 32'h2);
    startup = 1'b0; advance();
    startup = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("abort_valid", 32'(dbg_valid), 32'h0);
      chk("abort_done", 32'(dbg_done), 32'h0);
      advance();
    end

    // Randomized phase against the model.
    for (int n = 0; n < 400; n++) begin
      startup   = ($urandom_range(0, 39) != 0);
      wr_en     = 1'($urandom);
      wr_addr   = ADDR_W'($urandom);
      wr_data   = DATA_W'($urandom);
      rs1_addr  = ADDR_W'($urandom);
      rd_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom);
      dump_req  = ($urandom_range(0, 5) == 0);
      dbg_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
